fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the cotm32 core: owns the fetch PC and drives the combinational instruction memory address.
- Captures the returned instruction word into a small prefetch FIFO and presents {pc, inst, fault} to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap) by flushing and refetching.
- Sits between the branch/trap logic and instruction memory upstream, and decode downstream.

Parameters:
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.
- RESET_VECTOR, INST_MEM_START, fetch PC after reset.
- MEM_LO, INST_MEM_START, lowest fetchable byte address.
- MEM_HI, INST_MEM_END, highest fetchable byte address, inclusive.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- o_imem_addr  out  XLEN  fetch address to instruction memory; equals fetch_pc.
- i_imem_inst  in  INST_WIDTH  instruction word; combinational, valid in the same cycle as o_imem_addr.
- i_redirect  in  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  XLEN  redirect target.
- o_valid  out  1  FIFO head is valid.
- i_ready  in  1  decode accepts the head this cycle.
- o_pc  out  XLEN  PC of the head entry.
- o_inst  out  INST_WIDTH  instruction of the head entry.
- o_fault  out  2  fault code of the head entry (fetch_fault_e).

Behaviour:
- Reset (async assert): fetch_pc=RESET_VECTOR, FIFO empty, state=RUN, o_valid=0, o_pc='0, o_inst=NOP (32'h00000013), o_fault=FF_NONE, o_imem_addr=RESET_VECTOR.
- Whenever o_valid=0, o_pc, o_inst and o_fault show the reset values.
- pop = o_valid & i_ready. Handshake completes on the edge where pop=1.
- push (state RUN, no redirect) = FIFO not full, or pop this cycle. On push:
  - write {fetch_pc, i_imem_inst, FF_NONE}; fetch_pc += 4, wrapping modulo 2^XLEN.
  - No push means fetch_pc holds.
- Fault check on fetch_pc, evaluated before the push:
  - fetch_pc[1:0]!=0 gives FF_MISALIGNED.
  - fetch_pc<MEM_LO or fetch_pc+3>MEM_HI (computed XLEN+1 wide) gives FF_ACCESS.
  - Misaligned takes priority over access.
  - A faulting push writes {fetch_pc, NOP, code}, holds fetch_pc, and moves the state RUN->HALT.
- HALT: no pushes. Only i_redirect leaves HALT (to RUN). The FIFO still drains normally.
- Redirect in cycle N:
  - At the edge ending N: FIFO cleared (pointers and count), fetch_pc=i_redirect_pc, state=RUN, no push in N.
  - A pop in N still completes; decode owns that entry.
  - Cycle N+1: o_imem_addr=target, o_valid=0.
  - Cycle N+2: o_valid=1 with o_pc=target, or o_fault set if the target is bad. Redirect-to-valid is 2 cycles.
  - Redirect has priority over push, pop-refill and HALT.
- Throughput: one instruction per cycle sustained when i_ready=1. From reset the first valid appears in cycle 1.
- FIFO full with no pop: push stalls. Full with pop: push and pop in the same cycle, count unchanged.
- Count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset asserted mid-operation: immediate return to the reset state; in-flight entries are discarded.
- Outputs are registered from FIFO storage. No combinational path from i_ready or i_redirect to o_valid, o_pc, o_inst or o_fault. o_imem_addr is a register output.

Decomposition:
- cotm32_pkg additions: enum fetch_fault_e {FF_NONE=0, FF_MISALIGNED=1, FF_ACCESS=2} (2 bits); constant NOP_INST=32'h00000013; typedef fetch_entry_t struct {pc, inst, fault}.
- Sub-module fetch_fifo: parameterised DEPTH sync FIFO of fetch_entry_t with push/pop/flush and full/empty. Registered read data via head-pointer mux.
- fetch_unit holds fetch_pc, the RUN/HALT FSM, fault checks and push/pop control.

Test Plan:
- Reset release, RESET_VECTOR=0, i_ready=1 -> cycle 1 o_valid=1, o_pc=0; cycle 2 o_pc=4; cycle 3 o_pc=8; o_inst matches memory at each address.
- i_ready=0 for 5 cycles after reset (DEPTH=2) -> o_imem_addr stops at 0x8; on release, o_pc sequence is 0, 4, 8 with no gap or duplicate.
- Redirect to 0x40 in cycle N while o_valid=1 and i_ready=1 -> entry popped in N; o_valid=0 in N+1; o_pc=0x40 in N+2; old 0x4/0x8 entries never appear.
- Redirect to 0x42 -> N+2: o_fault=FF_MISALIGNED, o_inst=0x00000013; afterwards no further pushes and o_imem_addr stays 0x42 until a redirect to 0x10 resumes fetch at 0x10.
- Sequential fetch reaching MEM_HI-3 then MEM_HI+1 -> last good entry, then an entry with FF_ACCESS, then HALT.
- Async i_rst pulse mid-stream (between clock edges) -> o_valid=0 immediately; first post-reset o_pc=RESET_VECTOR.

Source files
------------

// File: rtl/cotm32_pkg.sv
// Shared cotm32 core types and constants used by the fetch stage.
// Holds the fetch fault encoding, the prefetch entry layout and the fetch-address check.
package cotm32_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_MEM_END   = 32'h0000_0FFF;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FF_NONE       = 2'd0,
        FF_MISALIGNED = 2'd1,
        FF_ACCESS     = 2'd2
    } fetch_fault_e;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
        fetch_fault_e          fault;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_IDLE = '{pc: '0, inst: NOP_INST, fault: FF_NONE};

    // The last byte of the word is computed one bit wider so a fetch near 2^XLEN cannot wrap past MEM_HI.
    function automatic fetch_fault_e fetch_fault_check(
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] hi
    );
        logic [XLEN:0] last_byte;
        fetch_fault_e  code;
        last_byte = {1'b0, pc} + (XLEN+1)'(3);
        if (pc[1:0] != 2'b00) begin
            code = FF_MISALIGNED;
        end else if ((pc < lo) || (last_byte > {1'b0, hi})) begin
            code = FF_ACCESS;
        end else begin
            code = FF_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with flush; the head entry is read straight from storage
// registers, and an empty FIFO presents the idle entry.
module fetch_fifo
    import cotm32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_IDLE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == CW'(0));

    // Head-pointer mux; decode sees the idle entry whenever nothing is queued.
    always_comb begin
        if (o_empty) begin
            o_rdata = ENTRY_IDLE;
        end else begin
            o_rdata = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// cotm32 instruction fetch stage: owns the fetch PC, checks each fetch address,
// queues {pc, inst, fault} for decode and restarts on redirects.
module fetch_unit
    import cotm32_pkg::*;
#(
    parameter int              DEPTH        = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = INST_MEM_START,
    parameter logic [XLEN-1:0] MEM_LO       = INST_MEM_START,
    parameter logic [XLEN-1:0] MEM_HI       = INST_MEM_END
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [XLEN-1:0]       o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_inst,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_redirect_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [1:0]            o_fault
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    fetch_state_e    state_q, state_d;

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    fetch_fault_e    fault_code;

    assign pop        = o_valid & i_ready;
    assign fault_code = fetch_fault_check(fetch_pc_q, MEM_LO, MEM_HI);

    // Fetch control: a redirect overrides everything; otherwise fetch while RUN and a slot frees up.
    // A faulting address is queued once as a NOP carrying the fault, then fetch parks in HALT.
    always_comb begin
        push       = 1'b0;
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        wr_entry   = '{pc: fetch_pc_q, inst: i_imem_inst, fault: FF_NONE};
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            state_d    = FS_RUN;
        end else if ((state_q == FS_RUN) && (!fifo_full || pop)) begin
            push = 1'b1;
            if (fault_code == FF_NONE) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                wr_entry = '{pc: fetch_pc_q, inst: NOP_INST, fault: fault_code};
                state_d  = FS_HALT;
            end
        end else begin
            push = 1'b0;
        end
    end

    // Fetch PC and RUN/HALT state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_VECTOR;
            state_q    <= FS_RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .i_wdata (wr_entry),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = ~fifo_empty;
    assign o_pc        = head.pc;
    assign o_inst      = head.inst;
    assign o_fault     = head.fault;

endmodule
